// File: rtl/booth_seq_sched.sv
// rtl/booth_seq_sched.sv - two-port round-robin front end over a sequential radix-2 Booth multiplier
module booth_seq_sched #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_x,
  input  logic [W-1:0]   req0_y,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_x,
  input  logic [W-1:0]   req1_y,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*W-1:0] rsp_z,
  output logic           busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(W + 1);

  logic [1:0]     state;
  logic           last;
  logic [W:0]     a;
  logic [W:0]     m;
  logic [W-1:0]   q;
  logic           q_m1;
  logic [CW-1:0]  cnt;
  logic           id;
  logic [2*W-1:0] z;
  logic [W:0]     a_sum;
  logic [W:0]     a_next;
  logic [W-1:0]   q_next;

  // A tie goes to the port that was not served last; last resets to 1 so port 0 wins first.
  assign req0_ready = (state == IDLE) && req0_valid && (!req1_valid || last);
  assign req1_ready = (state == IDLE) && req1_valid && (!req0_valid || !last);

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign rsp_id    = id;
  assign rsp_z     = z;

  // The extra sign bit of A absorbs M = -2^(W-1) without a special case.
  always_comb begin
    case ({q[0], q_m1})
      2'b10:   a_sum = a - m;
      2'b01:   a_sum = a + m;
      default: a_sum = a;
    endcase
    a_next = {a_sum[W], a_sum[W:1]};
    q_next = {a_sum[0], q[W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      a     <= '0;
      m     <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
      id    <= 1'b0;
      z     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            a     <= '0;
            q_m1  <= 1'b0;
            id    <= req1_ready;
            last  <= req1_ready;
            cnt   <= CW'(W);
            state <= ITER;
            if (req1_ready) begin
              q <= req1_x;
              m <= {req1_y[W-1], req1_y};
            end else begin
              q <= req0_x;
              m <= {req0_y[W-1], req0_y};
            end
          end
        end
        ITER: begin
          a    <= a_next;
          q    <= q_next;
          q_m1 <= q[0];
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            z     <= {a_next[W-1:0], q_next};
            state <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_sched.sv
// tb/tb_booth_seq_sched.sv - scoreboard bench for booth_seq_sched at W=4
module tb_booth_seq_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0;
  logic       req0_ready;
  logic [3:0] req0_x = '0;
  logic [3:0] req0_y = '0;
  logic       req1_valid = 1'b0;
  logic       req1_ready;
  logic [3:0] req1_x = '0;
  logic [3:0] req1_y = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_id;
  logic [7:0] rsp_z;
  logic       busy;

  int checks = 0;
  int failures = 0;
  logic [8:0] sb[$];

  booth_seq_sched #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] exp_z(input logic [3:0] x, input logic [3:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at #1 after a rising edge; holds rsp_ready low for `hold` DONE cycles.
  task automatic collect(input int hold);
    int n;
    logic [8:0] e;
    logic [7:0] z0;
    logic id0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rsp_timeout", 32'(n < 100), 1);
    z0 = rsp_z;
    id0 = rsp_id;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_z", rsp_z, z0);
      check("hold_id", rsp_id, id0);
      check("hold_readys", {req0_ready, req1_ready}, 0);
    end
    rsp_ready = 1'b1;
    check("sb_nonempty", 32'(sb.size() > 0), 1);
    e = (sb.size() > 0) ? sb.pop_front() : 9'h0;
    check("rsp_z", rsp_z, e[7:0]);
    check("rsp_id", rsp_id, e[8]);
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic do_op(input logic port, input logic [3:0] x, input logic [3:0] y,
                       input int gap, input int hold);
    int n;
    repeat (gap) tick();
    if (port) begin
      req1_valid = 1'b1; req1_x = x; req1_y = y;
    end else begin
      req0_valid = 1'b1; req0_x = x; req0_y = y;
    end
    n = 0;
    @(negedge clk);
    while (!(port ? req1_ready : req0_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 50), 1);
    sb.push_back({port, exp_z(x, y)});
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    collect(hold);
  endtask

  initial begin
    int n;
    int seen;
    logic [7:0] prev_z;
    logic [7:0] iv;

    // Reset values
    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_z", rsp_z, 0);
    check("rst_id", rsp_id, 0);
    check("rst_readys", {req0_ready, req1_ready}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Arbitration: both valid, grants alternate 0,1,0,1 starting with port 0
    req0_valid = 1'b1; req0_x = 4'd2; req0_y = 4'd3;
    req1_valid = 1'b1; req1_x = 4'hF; req1_y = 4'd5;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge clk);
      while (!(req0_ready || req1_ready) && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("arb_timeout", 32'(n < 50), 1);
      check("arb_excl", req0_ready & req1_ready, 0);
      check("arb_order", req1_ready, k % 2);
      sb.push_back({req1_ready, req1_ready ? exp_z(4'hF, 4'd5) : exp_z(4'd2, 4'd3)});
      tick();
      collect(0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Latency: 3 * -2 with rsp_valid rising exactly in cycle 5
    prev_z = rsp_z;
    req0_valid = 1'b1; req0_x = 4'd3; req0_y = 4'hE;
    @(negedge clk);
    check("lat_ready", req0_ready, 1);
    sb.push_back({1'b0, 8'hFA});
    tick();
    req0_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("lat_iter_valid", rsp_valid, 0);
      check("lat_iter_busy", busy, 1);
      check("lat_iter_z", rsp_z, prev_z);
      tick();
    end
    @(negedge clk);
    check("lat_valid", rsp_valid, 1);
    check("lat_z", rsp_z, 8'hFA);
    tick();

    // Backpressure with a waiting request on port 1, then IDLE right after the handshake
    req1_valid = 1'b1; req1_x = 4'h8; req1_y = 4'd7;
    collect(5);
    @(negedge clk);
    check("bp_idle", busy, 0);
    check("bp_next_ready", req1_ready, 1);
    sb.push_back({1'b1, exp_z(4'h8, 4'd7)});
    tick();
    req1_valid = 1'b0;
    collect(0);

    // Most-negative operands
    do_op(1'b0, 4'h8, 4'h8, 0, 1);
    do_op(1'b1, 4'h8, 4'd7, 1, 0);
    do_op(1'b0, 4'd7, 4'h8, 0, 2);
    check("mn_last_z", rsp_z, 8'hC8);

    // Reset during the second ITER cycle discards the operation
    req1_valid = 1'b1; req1_x = 4'd5; req1_y = 4'd5;
    n = 0;
    @(negedge clk);
    while (!req1_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rm_accept", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("rm_busy", busy, 0);
    check("rm_valid", rsp_valid, 0);
    check("rm_z", rsp_z, 0);
    check("rm_id", rsp_id, 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rm_no_rsp", seen, 0);
    tick();
    do_op(1'b0, 4'hD, 4'd6, 0, 1);

    // Exhaustive products with random gaps and backpressure
    for (int i = 0; i < 256; i++) begin
      iv = i[7:0];
      do_op(iv[0] ^ iv[4], iv[7:4], iv[3:0], $urandom_range(0, 2), $urandom_range(0, 2));
    end

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
